cus19_lsu: RTL and testbench

- Load/store unit for pipeline stage 3. It is the initiator side of the data-memory byte interface.
- Accepts one 19-bit-register load or store request at a time and breaks it into 8-bit memory beats: 1 beat for a byte access, 3 beats for a word access.
- Drives the memory's read-enable, address, write-enable and write-data lines, and samples the memory's combinational read data.
- Returns the assembled, zero-extended load result, or a store acknowledge, with an error flag.

---
 rtl/cus19_lsu.sv | 153 +++++++++++++++
 tb/tb_cus19_lsu.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cus19_lsu.sv
// Load/store unit for pipeline stage 3: splits one 19-bit load or store
// into 8-bit memory beats and returns the assembled result or a store ack.
module cus19_lsu #(
    parameter int Mem_Addr_Width = 11,
    parameter int Data_Width     = 8,
    parameter int Word_Width     = 19
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      req_valid_in,
    output logic                      req_ready_out,
    input  logic                      req_wr_in,
    input  logic                      req_word_in,
    input  logic [Mem_Addr_Width-1:0] req_addr_in,
    input  logic [Word_Width-1:0]     req_wdata_in,
    output logic                      mem_rd_out,
    output logic [Mem_Addr_Width-1:0] rd_addr_out,
    input  logic [Data_Width-1:0]     rd_data_in,
    output logic                      mem_wr_out,
    output logic [Mem_Addr_Width-1:0] wr_addr_out,
    output logic [Data_Width-1:0]     wr_data_out,
    output logic                      resp_valid_out,
    output logic                      resp_err_out,
    output logic [Word_Width-1:0]     resp_rdata_out
);

    localparam int Asm_Width = 3 * Data_Width;
    // Highest base address a 3-byte word may start at without wrapping.
    localparam logic [Mem_Addr_Width-1:0] Word_Addr_Max =
        {Mem_Addr_Width{1'b1}} - Mem_Addr_Width'(2);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [1:0]                beat_q;
    logic                      wr_q;
    logic                      word_q;
    logic                      err_q;
    logic [Mem_Addr_Width-1:0] addr_q;
    logic [Word_Width-1:0]     wdata_q;
    logic [Word_Width-1:0]     rdata_q;
    logic [Asm_Width-1:0]      asm_q;
    logic [Asm_Width-1:0]      asm_d;
    logic [Asm_Width-1:0]      wdata_ext;
    logic [Mem_Addr_Width-1:0] beat_addr;
    logic                      accept;
    logic                      reject;
    logic                      last_beat;

    assign accept    = req_valid_in && (state_q == IDLE);
    assign reject    = req_word_in && (req_addr_in > Word_Addr_Max);
    assign last_beat = word_q ? (beat_q == 2'd2) : (beat_q == 2'd0);
    assign beat_addr = addr_q + Mem_Addr_Width'(beat_q);
    // Upper byte of a word carries the top register bits zero-padded.
    assign wdata_ext = Asm_Width'(wdata_q);
    assign resp_rdata_out = rdata_q;

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d        = state_q;
        req_ready_out  = 1'b0;
        mem_rd_out     = 1'b0;
        mem_wr_out     = 1'b0;
        rd_addr_out    = '0;
        wr_addr_out    = '0;
        wr_data_out    = '0;
        resp_valid_out = 1'b0;
        resp_err_out   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_out = 1'b1;
                if (accept) begin
                    state_d = reject ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                // Strobes are qualified by reset so a beat in flight when
                // reset lands is not committed by the memory.
                if (wr_q) begin
                    mem_wr_out  = rst_in;
                    wr_addr_out = beat_addr;
                    wr_data_out = wdata_ext[beat_q*Data_Width +: Data_Width];
                end else begin
                    mem_rd_out  = rst_in;
                    rd_addr_out = beat_addr;
                end
                if (last_beat) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid_out = 1'b1;
                resp_err_out   = err_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load assembly: current beat's read byte merged into the partial word.
    always_comb begin
        asm_d = asm_q;
        asm_d[beat_q*Data_Width +: Data_Width] = rd_data_in;
    end

    // Request latch, beat counter and load result.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            beat_q  <= 2'd0;
            wr_q    <= 1'b0;
            word_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                wr_q    <= req_wr_in;
                word_q  <= req_word_in;
                addr_q  <= req_addr_in;
                wdata_q <= req_wdata_in;
                err_q   <= reject;
                beat_q  <= 2'd0;
            end
            if (state_q == ACCESS) begin
                beat_q <= last_beat ? 2'd0 : beat_q + 2'd1;
                if (!wr_q) begin
                    asm_q <= asm_d;
                    if (last_beat) begin
                        rdata_q <= word_q ? Word_Width'(asm_d)
                                          : Word_Width'(rd_data_in);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cus19_lsu.sv
// Testbench for cus19_lsu: byte-addressed memory model plus a
// transaction-level reference of memory contents and load results.
module tb_cus19_lsu;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic        req_wr_in = 1'b0;
    logic        req_word_in = 1'b0;
    logic [10:0] req_addr_in = '0;
    logic [18:0] req_wdata_in = '0;
    logic        mem_rd_out;
    logic [10:0] rd_addr_out;
    logic [7:0]  rd_data_in;
    logic        mem_wr_out;
    logic [10:0] wr_addr_out;
    logic [7:0]  wr_data_out;
    logic        resp_valid_out;
    logic        resp_err_out;
    logic [18:0] resp_rdata_out;

    logic [7:0]  mem     [0:2047];
    logic [7:0]  ref_mem [0:2047];
    logic [18:0] exp_rdata = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    cus19_lsu #(
        .Mem_Addr_Width(11),
        .Data_Width(8),
        .Word_Width(19)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .req_valid_in(req_valid_in),
        .req_ready_out(req_ready_out),
        .req_wr_in(req_wr_in),
        .req_word_in(req_word_in),
        .req_addr_in(req_addr_in),
        .req_wdata_in(req_wdata_in),
        .mem_rd_out(mem_rd_out),
        .rd_addr_out(rd_addr_out),
        .rd_data_in(rd_data_in),
        .mem_wr_out(mem_wr_out),
        .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out),
        .resp_valid_out(resp_valid_out),
        .resp_err_out(resp_err_out),
        .resp_rdata_out(resp_rdata_out)
    );

    always #5 clk_in = ~clk_in;

    // Memory: combinational read, write committed on the rising edge.
    assign rd_data_in = mem[rd_addr_out];
    always @(posedge clk_in) begin
        if (mem_wr_out) mem[wr_addr_out] <= wr_data_out;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [18:0] w, input int b);
        return 8'(w >> (8 * b));
    endfunction

    // One request through the DUT, checked against the reference.
    // With hold=1 the next request is presented (valid high) while busy.
    task automatic do_req(input logic wr, input logic word, input logic [10:0] a,
                          input logic [18:0] wd, input bit hold,
                          input logic nwr, input logic nword, input logic [10:0] na,
                          input logic [18:0] nwd, output int waited);
        bit          e_err;
        int          e_lat;
        int          e_beats;
        int          lat = 0;
        int          rd_cnt = 0;
        int          wr_cnt = 0;
        int          bad = 0;
        int          busy_ready = 0;
        int          both = 0;
        bit          got_ready = 0;
        logic        r_err = 1'b0;
        logic [18:0] r_data = '0;
        logic [18:0] pre_rdata;
        logic [10:0] ba;

        e_err   = word && (a > 11'd2045);
        e_lat   = e_err ? 1 : (word ? 4 : 2);
        e_beats = e_err ? 0 : (word ? 3 : 1);
        pre_rdata = exp_rdata;
        waited = 0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            req_valid_in = 1'b1;
            req_wr_in    = wr;
            req_word_in  = word;
            req_addr_in  = a;
            req_wdata_in = wd;
            if (req_ready_out) begin
                got_ready = 1;
                break;
            end
            waited++;
        end
        chk("ready_wait", got_ready, 1);
        if (!got_ready) begin
            req_valid_in = 1'b0;
            return;
        end

        if (!e_err && !wr) begin
            if (word) exp_rdata = {ref_mem[a + 11'd2][2:0], ref_mem[a + 11'd1], ref_mem[a]};
            else      exp_rdata = {11'b0, ref_mem[a]};
        end

        @(posedge clk_in);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk_in);
            if (req_ready_out) busy_ready++;
            if (mem_rd_out && mem_wr_out) both++;
            if (mem_rd_out) begin
                ba = a + 11'(rd_cnt);
                if (rd_addr_out !== ba) bad++;
                rd_cnt++;
            end
            if (mem_wr_out) begin
                ba = a + 11'(wr_cnt);
                if (wr_addr_out !== ba || wr_data_out !== exp_byte(wd, wr_cnt)) bad++;
                wr_cnt++;
            end
            if (!mem_rd_out && !mem_wr_out &&
                (rd_addr_out !== 11'd0 || wr_addr_out !== 11'd0 || wr_data_out !== 8'd0)) bad++;
            if (n == 1) begin
                if (hold) begin
                    req_wr_in    = nwr;
                    req_word_in  = nword;
                    req_addr_in  = na;
                    req_wdata_in = nwd;
                end else begin
                    req_valid_in = 1'b0;
                    req_wr_in    = 1'($urandom);
                    req_word_in  = 1'($urandom);
                    req_addr_in  = 11'($urandom);
                    req_wdata_in = 19'($urandom);
                end
            end
            if (resp_valid_out) begin
                lat    = n;
                r_err  = resp_err_out;
                r_data = resp_rdata_out;
                break;
            end
        end

        if (!e_err && wr) begin
            for (int b = 0; b < e_beats; b++) ref_mem[a + 11'(b)] = exp_byte(wd, b);
        end

        chk("latency", lat, e_lat);
        chk("resp_err", r_err, e_err);
        chk("resp_rdata", r_data, exp_rdata);
        chk("rd_beats", rd_cnt, wr ? 0 : e_beats);
        chk("wr_beats", wr_cnt, wr ? e_beats : 0);
        chk("beat_addr_data", bad, 0);
        chk("busy_ready_low", busy_ready, 0);
        chk("rd_wr_exclusive", both, 0);
        if (wr || e_err) chk("rdata_held", r_data, pre_rdata);
    endtask

    initial begin
        int          w;
        int          diff;
        bit          seen;
        logic [18:0] wd;
        logic [10:0] a;
        int          sel;

        for (int i = 0; i < 2048; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if (i == 'h10) v = 8'hAB;
            if (i == 'h11) v = 8'hCD;
            if (i == 'h12) v = 8'hFF;
            if (i == 'h7FF) v = 8'h80;
            mem[i] <= v;
            ref_mem[i] = v;
        end

        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rst_ready", req_ready_out, 1);
        chk("rst_outs", {mem_rd_out, mem_wr_out, resp_valid_out, resp_err_out}, 4'b0);
        chk("rst_rdata", resp_rdata_out, 0);
        chk("rst_addrs", {rd_addr_out, wr_addr_out, wr_data_out}, 0);

        // Word load at 0x10
        do_req(0, 1, 11'h010, 19'h0, 0, 0, 0, 0, 0, w);
        chk("tp1_rdata", resp_rdata_out, 19'h7CDAB);

        // Word store 0x5A5A5 at 0x20
        do_req(1, 1, 11'h020, 19'h5A5A5, 0, 0, 0, 0, 0, w);
        chk("tp2_m20", mem['h20], 8'hA5);
        chk("tp2_m21", mem['h21], 8'hA5);
        chk("tp2_m22", mem['h22], 8'h05);

        // Top-of-memory byte load and rejected word load
        do_req(0, 0, 11'h7FF, 19'h0, 0, 0, 0, 0, 0, w);
        chk("tp3_rdata", resp_rdata_out, 19'h00080);
        do_req(0, 1, 11'h7FE, 19'h0, 0, 0, 0, 0, 0, w);
        do_req(1, 1, 11'h7FD, 19'h12345, 0, 0, 0, 0, 0, w);
        do_req(0, 1, 11'h7FD, 19'h0, 0, 0, 0, 0, 0, w);

        // Two loads with valid held high throughout
        do_req(0, 1, 11'h010, 19'h0, 1, 0, 0, 11'h7FF, 19'h0, w);
        do_req(0, 0, 11'h7FF, 19'h0, 0, 0, 0, 0, 0, w);
        chk("b2b_accept_first_idle", w, 0);

        // Reset during beat 1 of a word store to 0x30
        wd = 19'($urandom);
        @(negedge clk_in);
        chk("rst_mid_ready", req_ready_out, 1);
        req_valid_in = 1'b1; req_wr_in = 1'b1; req_word_in = 1'b1;
        req_addr_in = 11'h030; req_wdata_in = wd;
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid_in = 1'b0;
        seen = resp_valid_out;
        @(negedge clk_in);
        seen |= resp_valid_out;
        chk("rst_mid_beat1_addr", wr_addr_out, 11'h031);
        rst_in = 1'b0;
        @(negedge clk_in);
        seen |= resp_valid_out;
        chk("rst_mid_outs", {mem_rd_out, mem_wr_out, resp_valid_out, resp_err_out}, 4'b0);
        chk("rst_mid_addrs", {rd_addr_out, wr_addr_out, wr_data_out}, 0);
        chk("rst_mid_ready_after", req_ready_out, 1);
        chk("rst_mid_rdata", resp_rdata_out, 0);
        rst_in = 1'b1;
        @(negedge clk_in);
        seen |= resp_valid_out;
        chk("rst_mid_no_resp", seen, 0);
        ref_mem['h30] = exp_byte(wd, 0);
        exp_rdata = '0;
        chk("rst_mid_m30", mem['h30], exp_byte(wd, 0));
        chk("rst_mid_m31", mem['h31], ref_mem['h31]);
        chk("rst_mid_m32", mem['h32], ref_mem['h32]);

        // Byte store of 0x7FFFF to 0x40
        do_req(1, 0, 11'h040, 19'h7FFFF, 0, 0, 0, 0, 0, w);
        chk("tp6_m40", mem['h40], 8'hFF);
        chk("tp6_m41", mem['h41], ref_mem['h41]);

        // Random traffic, biased toward the top-of-memory boundary
        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 7));
            a = (sel < 3) ? 11'(2045 + sel) : 11'($urandom);
            do_req(1'($urandom), 1'($urandom), a, 19'($urandom), 0, 0, 0, 0, 0, w);
        end

        diff = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== ref_mem[i]) diff++;
        chk("mem_image", diff, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
